// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam logic [3:0] DIGIT_DASH  = 4'hA;
  localparam logic [3:0] DIGIT_BLANK = 4'hB;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational add-3 correction cell for one BCD digit of the shift datapath.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = add3(i_digit);

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential shift-add-3 binary-to-BCD converter with start/busy/done handshake.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 7,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [BIN_W-1:0]    i_bin,
  output logic                o_busy,
  output logic                o_done,
  output logic [4*DIGITS-1:0] o_bcd
);

  localparam int CNT_W = $clog2(BIN_W);
  localparam int DW    = 4 * DIGITS;

  localparam logic [BIN_W-1:0] BIN_DASH  = '1;
  localparam logic [BIN_W-1:0] BIN_BLANK = {{(BIN_W-1){1'b1}}, 1'b0};

  if (BIN_W < 3 || (DIGITS < 19 && BIN_W < 64 && (64'd10 ** DIGITS) < (64'd1 << BIN_W)))
  begin : g_param_err
    $error("bcd_seq_converter: DIGITS too small for BIN_W");
  end

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [BIN_W-1:0]    r_bin_sr;
  logic [DW-1:0]       r_digits;
  logic                r_dash;
  logic                r_blank;
  logic                r_busy;
  logic                r_done;
  logic [DW-1:0]       r_bcd;

  logic [DW-1:0]       w_adj;
  logic [DW+BIN_W-1:0] w_shift;
  logic [DW-1:0]       w_result;
  logic                w_unused_top;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_digits[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // Top bit of the adjusted digits is shifted out; the parameter check keeps it zero.
  assign w_shift      = {w_adj[DW-2:0], r_bin_sr, 1'b0};
  assign w_unused_top = w_adj[DW-1];

  always_comb begin
    w_result = r_digits;
`ifdef LEADING_ZERO_BLANK_EN
    begin : b_lead
      logic w_lead;
      w_lead = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
        if (w_lead && (r_digits[4*k +: 4] == 4'd0)) begin
          w_result[4*k +: 4] = DIGIT_BLANK;
        end else begin
          w_lead = 1'b0;
        end
      end
    end
`endif
    if (r_dash) begin
      w_result = {DIGITS{DIGIT_DASH}};
    end else if (r_blank) begin
      w_result = {DIGITS{DIGIT_BLANK}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bin_sr <= '0;
      r_digits <= '0;
      r_dash   <= 1'b0;
      r_blank  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bcd    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_bin_sr <= i_bin;
            r_digits <= '0;
            r_cnt    <= CNT_W'(BIN_W - 1);
            r_dash   <= (i_bin == BIN_DASH);
            r_blank  <= (i_bin == BIN_BLANK);
            r_busy   <= 1'b1;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          {r_digits, r_bin_sr} <= w_shift;
          r_cnt                <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_state <= FINISH;
          end
        end
        FINISH: begin
          r_bcd   <= w_result;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_bcd  = r_bcd;

endmodule
